// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern generator: mode codes, the initial
// pattern loaded on entry to each mode, the BOUNCE direction type and the
// default timing parameters (tuned for a 50 MHz board clock).
// No ports; imported by led_pattern_gen and btn_debounce.
// ---------------------------------------------------------------------------
package led_pkg;

    // 4 Hz pattern step and 20 ms debounce window at 50 MHz
    localparam int DEFAULT_CLK_DIV = 12_500_000;
    localparam int DEFAULT_DB_CNT  = 1_000_000;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_t;

    // Right moves the lit LED toward led_9 (towards P[0])
    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam logic [4:0] INIT_OFF    = 5'b00000;
    localparam logic [4:0] INIT_CHASE  = 5'b10000;
    localparam logic [4:0] INIT_BOUNCE = 5'b10000;
    localparam logic [4:0] INIT_BLINK  = 5'b11111;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_OFF:    nxt = MODE_CHASE;
            MODE_CHASE:  nxt = MODE_BOUNCE;
            MODE_BOUNCE: nxt = MODE_BLINK;
            default:     nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

    function automatic logic [4:0] init_pattern(input mode_t m);
        logic [4:0] p;
        case (m)
            MODE_CHASE:  p = INIT_CHASE;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_BLINK:  p = INIT_BLINK;
            default:     p = INIT_OFF;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw, bouncing push button into the clock domain and filters
// it: the debounced level only follows the synchronized input after it has
// disagreed for DB_CNT consecutive cycles. Emits a one-cycle pulse on each
// accepted press (0->1 of the debounced level); releases give no pulse.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   btn_raw   in   raw asynchronous button, active-high
//   btn_level out  debounced button level
//   btn_press out  one-cycle press pulse, registered
// ---------------------------------------------------------------------------
module btn_debounce
    import led_pkg::*;
#(
    parameter int DB_CNT = DEFAULT_DB_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int              CNT_W    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] db_count;

    // db_count holds how many consecutive earlier cycles already disagreed,
    // so reaching CNT_LAST on another disagreeing cycle completes the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            db_count  <= '0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            sync_0    <= btn_raw;
            sync_1    <= sync_0;
            btn_press <= 1'b0;
            if (sync_1 != btn_level) begin
                if (db_count == CNT_LAST) begin
                    btn_level <= sync_1;
                    btn_press <= sync_1;
                    db_count  <= '0;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Five-LED pattern generator. A debounced push button cycles the mode
// OFF -> CHASE -> BOUNCE -> BLINK -> OFF; a prescaler produces the pattern
// step tick while running. P[4] drives led_1, P[0] drives led_9.
//
// Ports:
//   clk                          in   system clock, rising edge
//   rst_n                        in   asynchronous active-low reset
//   btn                          in   raw bouncing mode button, active-high
//   sw_1                         in   run enable (1 = step, 0 = pause)
//   sw_3                         in   CHASE direction (0 = toward led_9)
//   sw_5                         in   blank all LEDs, sequence keeps going
//   led_1/3/5/7/9                out  registered LED drives, active-high
//   mode                         out  current mode code
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int DB_CNT  = DEFAULT_DB_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       sw_1,
    input  logic       sw_3,
    input  logic       sw_5,
    output logic       led_1,
    output logic       led_3,
    output logic       led_5,
    output logic       led_7,
    output logic       led_9,
    output logic [1:0] mode
);

    localparam int                PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic               btn_level_unused;
    logic               btn_press;
    mode_t              mode_q;
    dir_t               dir;
    dir_t               dir_next;
    logic [PRESC_W-1:0] presc;
    logic [4:0]         pattern;
    logic [4:0]         pattern_next;
    logic [4:0]         leds;
    logic               counting;
    logic               tick;

    btn_debounce #(
        .DB_CNT(DB_CNT)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn),
        .btn_level(btn_level_unused),
        .btn_press(btn_press)
    );

    assign counting = sw_1 && (mode_q != MODE_OFF);
    assign tick     = counting && (presc == PRESC_LAST);

    // Next pattern and BOUNCE direction. A press overrides a coincident tick.
    // BOUNCE flips direction on the step that lands on an end LED, so the
    // following tick already heads back and the pattern never wraps.
    always_comb begin
        pattern_next = pattern;
        dir_next     = dir;
        if (btn_press) begin
            pattern_next = init_pattern(next_mode(mode_q));
            dir_next     = DIR_RIGHT;
        end else if (tick) begin
            case (mode_q)
                MODE_CHASE: begin
                    if (sw_3)
                        pattern_next = {pattern[3:0], pattern[4]};
                    else
                        pattern_next = {pattern[0], pattern[4:1]};
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_RIGHT) begin
                        pattern_next = pattern >> 1;
                        if (pattern[1])
                            dir_next = DIR_LEFT;
                    end else begin
                        pattern_next = pattern << 1;
                        if (pattern[3])
                            dir_next = DIR_RIGHT;
                    end
                end
                MODE_BLINK: pattern_next = ~pattern;
                default:    pattern_next = pattern;
            endcase
        end
    end

    // Mode FSM, prescaler, pattern and LED output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            presc   <= '0;
            pattern <= INIT_OFF;
            dir     <= DIR_RIGHT;
            leds    <= '0;
        end else begin
            if (btn_press) begin
                mode_q <= next_mode(mode_q);
                presc  <= '0;
            end else if (counting) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
            pattern <= pattern_next;
            dir     <= dir_next;
            leds    <= pattern_next & ~{5{sw_5}};
        end
    end

    assign {led_1, led_3, led_5, led_7, led_9} = leds;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Self-checking bench for led_pattern_gen with CLK_DIV=4, DB_CNT=3.
// A behavioural model tracks mode, ticks since mode entry and LED position
// in plain arithmetic, and the button filter as "last DB_CNT synchronized
// samples all disagree with the accepted level".
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

    localparam int CLK_DIV = 4;
    localparam int DB_CNT  = 3;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       sw_1;
    logic       sw_3;
    logic       sw_5;
    logic       led_1, led_3, led_5, led_7, led_9;
    logic [1:0] mode;
    logic [4:0] leds;

    int vectors;
    int miscompares;
    int dut_presses;

    // Behavioural model state
    int         m_mode;
    int         m_n;
    int         m_en;
    int         m_pos;
    int         m_presses;
    bit         m_press_pend;
    bit         m_level;
    bit         m_s0;
    bit         m_s1;
    bit         m_sync_q[$];
    logic [4:0] m_led;

    int         bounce_pos[8]  = '{0, 1, 2, 3, 4, 3, 2, 1};
    logic [4:0] chase_tbl[6]   = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    logic [4:0] bounce_tbl[10] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001,
                                   5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000};

    led_pattern_gen #(
        .CLK_DIV(CLK_DIV),
        .DB_CNT (DB_CNT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .sw_1 (sw_1),
        .sw_3 (sw_3),
        .sw_5 (sw_5),
        .led_1(led_1),
        .led_3(led_3),
        .led_5(led_5),
        .led_7(led_7),
        .led_9(led_9),
        .mode (mode)
    );

    assign leds = {led_1, led_3, led_5, led_7, led_9};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.u_debounce.btn_press === 1'b1)
            dut_presses++;
    end

    function automatic logic [4:0] model_pattern();
        logic [4:0] p;
        p = 5'b00000;
        case (m_mode)
            1:       p = 5'b10000 >> m_pos;
            2:       p = 5'b10000 >> bounce_pos[m_n % 8];
            3:       p = (m_n % 2 == 0) ? 5'b11111 : 5'b00000;
            default: p = 5'b00000;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        m_mode       = 0;
        m_n          = 0;
        m_en         = 0;
        m_pos        = 0;
        m_press_pend = 1'b0;
        m_level      = 1'b0;
        m_s0         = 1'b0;
        m_s1         = 1'b0;
        m_sync_q.delete();
        m_led        = 5'b00000;
    endtask

    // One rising edge of the model, using the inputs the DUT just sampled
    task automatic model_edge();
        bit tick;
        bit flip;
        tick = (m_mode != 0) && sw_1 && (m_en % CLK_DIV == CLK_DIV - 1);
        if (m_press_pend) begin
            m_mode = (m_mode + 1) % 4;
            m_n    = 0;
            m_en   = 0;
            m_pos  = 0;
        end else if (m_mode != 0 && sw_1) begin
            m_en++;
            if (tick) begin
                m_n++;
                if (m_mode == 1)
                    m_pos = sw_3 ? (m_pos + 4) % 5 : (m_pos + 1) % 5;
            end
        end
        m_led = model_pattern() & ~{5{sw_5}};

        m_sync_q.push_back(m_s1);
        if (m_sync_q.size() > DB_CNT)
            void'(m_sync_q.pop_front());
        flip = (m_sync_q.size() == DB_CNT);
        foreach (m_sync_q[k])
            if (m_sync_q[k] == m_level)
                flip = 1'b0;
        m_press_pend = 1'b0;
        if (flip) begin
            m_level      = ~m_level;
            m_press_pend = m_level;
            if (m_level)
                m_presses++;
        end
        m_s1 = m_s0;
        m_s0 = btn;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn   = 1'b0;
        sw_1  = 1'b0;
        sw_3  = 1'b0;
        sw_5  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (leds !== 5'b00000 || mode !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: leds=%b mode=%b expected leds=00000 mode=00", leds, mode);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL reset_release[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
    endtask

    task automatic test_first_press();
        for (int i = 0; i < 20; i++) begin
            btn = (i < 10);
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL first_press[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        vectors++;
        if (mode !== 2'b01 || leds !== 5'b10000) begin
            miscompares++;
            $display("[TB] FAIL first_press_end: leds=%b mode=%b expected leds=10000 mode=01", leds, mode);
        end
        vectors++;
        if (dut_presses != 1) begin
            miscompares++;
            $display("[TB] FAIL first_press_pulses: got %0d pulses expected 1", dut_presses);
        end
    endtask

    task automatic test_glitch();
        int run;
        for (int i = 0; i < 20; i++) begin
            btn = (i % 2 == 0);
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL glitch_toggle[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        // random bursts shorter than the debounce window
        for (int b = 0; b < 10; b++) begin
            btn = ~btn;
            run = $urandom_range(1, DB_CNT - 1);
            for (int i = 0; i < run; i++) begin
                cycle();
                vectors++;
                if (leds !== m_led || mode !== m_mode[1:0]) begin
                    miscompares++;
                    $display("[TB] FAIL glitch_burst[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                             b, leds, mode, m_led, m_mode[1:0]);
                end
            end
        end
        btn = 1'b0;
        repeat (8) cycle();
        vectors++;
        if (mode !== 2'b01 || dut_presses != m_presses) begin
            miscompares++;
            $display("[TB] FAIL glitch_end: mode=%b pulses=%0d expected mode=01 pulses=%0d",
                     mode, dut_presses, m_presses);
        end
    endtask

    task automatic test_chase();
        sw_1 = 1'b1;
        sw_3 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            vectors++;
            if (leds !== chase_tbl[i / 4]) begin
                miscompares++;
                $display("[TB] FAIL chase_table[%0d]: leds=%b expected %b", i, leds, chase_tbl[i / 4]);
            end
            cycle();
        end
        for (int i = 0; i < 48; i++) begin
            sw_3 = 1'($urandom_range(0, 1));
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL chase_random[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        sw_3 = 1'b0;
    endtask

    task automatic test_bounce();
        int hold;
        btn = 1'b1;
        for (int i = 0; i < 12 && m_mode != 2; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL bounce_entry[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        btn = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vectors++;
            if (leds !== bounce_tbl[i / 4] || mode !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL bounce_table[%0d]: leds=%b mode=%b expected leds=%b mode=10",
                         i, leds, mode, bounce_tbl[i / 4]);
            end
            cycle();
        end
        sw_1 = 1'b0;
        hold = $urandom_range(5, 15);
        for (int i = 0; i < hold; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL bounce_pause[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        sw_1 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL bounce_resume[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
    endtask

    task automatic test_blink();
        int blank_len;
        btn = 1'b1;
        for (int i = 0; i < 12 && m_mode != 3; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL blink_entry[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        btn = 1'b0;
        sw_5 = 1'b1;
        blank_len = $urandom_range(13, 23);
        for (int i = 0; i < blank_len; i++) begin
            cycle();
            vectors++;
            if (leds !== 5'b00000 || mode !== 2'b11) begin
                miscompares++;
                $display("[TB] FAIL blink_blanked[%0d]: leds=%b mode=%b expected leds=00000 mode=11",
                         i, leds, mode);
            end
        end
        sw_5 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL blink_unblank[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
    endtask

    // btn rising with the prescaler at 2 makes the press pulse land on a tick:
    // 2 sync edges + DB_CNT filter edges, then the pulse is consumed.
    task automatic test_press_tick();
        for (int i = 0; i < 8 && (m_en % CLK_DIV) != 2; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL press_tick_align[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        for (int i = 0; i < 18; i++) begin
            btn = (i < 10);
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL press_tick[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        vectors++;
        if (mode !== 2'b00 || leds !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL press_tick_end: leds=%b mode=%b expected leds=00000 mode=00", leds, mode);
        end
    endtask

    task automatic test_async_reset();
        int run;
        for (int i = 0; i < 32; i++) begin
            btn = ((i % 16) < 8);
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL async_setup[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
        btn = 1'b0;
        run = $urandom_range(6, 20);
        for (int i = 0; i < run; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL async_bounce[%0d]: leds=%b mode=%b expected leds=%b mode=10",
                         i, leds, mode, m_led);
            end
        end
        // start a press so the filter is mid-count when reset hits
        btn = 1'b1;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (leds !== 5'b00000 || mode !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL async_reset: leds=%b mode=%b expected leds=00000 mode=00", leds, mode);
        end
        model_reset();
        btn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            vectors++;
            if (leds !== m_led || mode !== m_mode[1:0]) begin
                miscompares++;
                $display("[TB] FAIL async_release[%0d]: leds=%b mode=%b expected leds=%b mode=%b",
                         i, leds, mode, m_led, m_mode[1:0]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dut_presses = 0;
        m_presses   = 0;
        test_reset();
        test_first_press();
        test_glitch();
        test_chase();
        test_bounce();
        test_blink();
        test_press_tick();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 12_500_000, meaning clock cycles per pattern step (4 Hz at 50 MHz).
REQ-002 The block SHALL have parameter DB_CNT, default 1_000_000, meaning consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn, input, 1 bit: raw, asynchronous, bouncing push button, active-high; each press advances the mode.
REQ-006 The block SHALL have port sw_1, input, 1 bit: run enable; 1 = step, 0 = pause.
REQ-007 The block SHALL have port sw_3, input, 1 bit: CHASE direction; 0 = toward led_9, 1 = toward led_1.
REQ-008 The block SHALL have port sw_5, input, 1 bit: blank; 1 forces all LEDs off without stopping the sequence.
REQ-009 The block SHALL have ports led_1, led_3, led_5, led_7, led_9, output, 1 bit each: registered LED drives, active-high.
REQ-010 The block SHALL have port mode, output, 2 bits: current mode code.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL change only after the synchronized value differs from it for DB_CNT consecutive cycles; any mismatch break SHALL restart the count.
REQ-013 A press event SHALL be a 1-cycle pulse on each 0->1 transition of the debounced level; release SHALL generate no event.
REQ-014 The mode FSM SHALL step OFF(00) -> CHASE(01) -> BOUNCE(10) -> BLINK(11) -> OFF on each press event, and SHALL advance exactly one state per press.
REQ-015 The prescaler SHALL count 0..CLK_DIV-1 only while sw_1=1 and mode!=OFF, and SHALL hold its value while sw_1=0.
REQ-016 The tick SHALL assert for one cycle when the prescaler equals CLK_DIV-1 while counting; the prescaler SHALL wrap to 0 on that cycle.
REQ-017 The pattern register P[4:0] SHALL map to {led_1,led_3,led_5,led_7,led_9}, with P[4] driving led_1.
REQ-018 On entry to a mode, P SHALL load that mode's initial value: OFF 00000, CHASE 10000, BOUNCE 10000 with direction right, BLINK 11111.
REQ-019 On each tick in CHASE, P SHALL rotate right (00001 -> 10000) when sw_3=0 and rotate left (10000 -> 00001) when sw_3=1; sw_3 is sampled at the tick.
REQ-020 On each tick in BOUNCE, P SHALL shift one position in the current direction, reverse direction upon reaching 00001 or 10000, and never wrap (sequence 10000,01000,00100,00010,00001,00010,...).
REQ-021 On each tick in BLINK, P SHALL invert.
REQ-022 When a press event and a tick occur in the same cycle, the press SHALL win: the mode advances, P loads the new initial value, and the prescaler clears to 0.
REQ-023 The LED outputs SHALL equal P & ~{5{sw_5}}, registered, and SHALL update one cycle after the tick or press cycle.
REQ-024 The mode output SHALL update on the cycle after the press pulse.
REQ-025 The total latency from a clean btn rising edge to the mode change SHALL be 2 (sync) + DB_CNT + 2 cycles, with a tolerance of ±1.

Reset
REQ-026 While rst_n=0, the block SHALL hold mode=OFF, P=00000, all LEDs=0, prescaler=0, debounce count=0, debounced level=0, synchronizer flops=0, and BOUNCE direction=right.
REQ-027 Reset SHALL act immediately and asynchronously, including mid-debounce and mid-step; the block SHALL make no transition on the first clock edge after release except synchronizer sampling.

Structure
REQ-028 The mode codes, the initial patterns and the default CLK_DIV and DB_CNT values SHALL reside in the shared package led_pkg.
REQ-029 The synchronizer and debounce logic SHALL be the sub-module btn_debounce (ports clk, rst_n, btn_raw, btn_level, btn_press), reusable for other board buttons.
REQ-030 The FSM, prescaler and pattern logic SHALL reside in led_pattern_gen.

Verification (CLK_DIV=4, DB_CNT=3)
REQ-031 Verification SHALL apply reset then btn held 1 for 10 cycles -> exactly one press pulse, mode=01, LEDs 10000.
REQ-032 Verification SHALL toggle btn 0/1 every cycle for 20 cycles -> no press event and mode unchanged.
REQ-033 Verification SHALL run CHASE with sw_1=1 and sw_3=0 for 24 cycles -> LEDs 10000,01000,00100,00010,00001,10000, each held 4 cycles.
REQ-034 Verification SHALL run BOUNCE for 40 cycles -> LEDs 10000,01000,00100,00010,00001,00010,00100,01000,10000,01000; then sw_1=0 -> pattern and prescaler frozen.
REQ-035 Verification SHALL run BLINK with sw_5=1 -> LEDs 00000 while P still toggles; releasing sw_5 -> LEDs show the current P; a press coincident with a tick -> mode=OFF, LEDs 00000.
REQ-036 Verification SHALL assert rst_n=0 mid-BOUNCE, asynchronously between clock edges -> outputs 0 and mode 00 with no clock edge required.
